// File: rtl/watch_hms.sv
// Hours/minutes/seconds timekeeper with prescaler, checked time load and
// optional alarm latch (enabled by defining ALARM_EN).
module watch_hms #(
    parameter int TICK_DIV = 4,
    parameter int HOURS    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_minute,
    input  logic [5:0] load_second,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       alarm_arm,
    input  logic       alarm_clr,
    output logic       alarm
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [4:0]      HOUR_LAST = 5'(HOURS - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          load_ok;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap;
    logic [4:0]    hour_nx;
    logic [5:0]    minute_nx;
    logic [5:0]    second_nx;

    assign tick    = en && (presc == PRE_LAST);
    assign load_ok = load && (load_hour <= HOUR_LAST) &&
                     (load_minute <= 6'd59) && (load_second <= 6'd59);

    // Carry chain: each field wraps only when every lower field wraps too.
    assign sec_wrap  = (second == 6'd59);
    assign min_wrap  = sec_wrap && (minute == 6'd59);
    assign hour_wrap = min_wrap && (hour == HOUR_LAST);

    always_comb begin
        second_nx = sec_wrap ? 6'd0 : second + 6'd1;
        minute_nx = minute;
        hour_nx   = hour;
        if (sec_wrap) minute_nx = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        if (min_wrap) hour_nx   = (hour == HOUR_LAST) ? 5'd0 : hour + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= load && !load_ok;
            // A legal load discards a coincident tick; a rejected one lets it through.
            if (load_ok) begin
                hour   <= load_hour;
                minute <= load_minute;
                second <= load_second;
                presc  <= '0;
            end else begin
                if (en) presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    hour     <= hour_nx;
                    minute   <= minute_nx;
                    second   <= second_nx;
                    sec_tick <= 1'b1;
                    day_wrap <= hour_wrap;
                end
            end
        end
    end

`ifdef ALARM_EN
    logic alarm_hit;

    assign alarm_hit = tick && !load_ok && alarm_arm &&
                       (hour_nx == alarm_hour) && (minute_nx == alarm_minute) &&
                       (second_nx == 6'd0);

    // Clear (explicit or by disarming) takes priority over a same-cycle hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          alarm <= 1'b0;
        else if (alarm_clr || !alarm_arm) alarm <= 1'b0;
        else if (alarm_hit)               alarm <= 1'b1;
    end
`else
    logic unused_alarm;

    assign alarm        = 1'b0;
    assign unused_alarm = ^{alarm_hour, alarm_minute, alarm_arm, alarm_clr};
`endif

endmodule

// File: tb/tb_watch_hms.sv
// Bench for watch_hms: reset/count sequence, vector table, HOURS=24 wrap,
// alarm sequence, async reset, then randomized run against a seconds-of-day model.
module tb_watch_hms;

    localparam int TICK_DIV = 4;
    localparam int HOURS    = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_minute = '0;
    logic [5:0] load_second = '0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_minute = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_clr = 1'b0;

    logic [4:0] hour;
    logic [5:0] minute, second;
    logic       sec_tick, day_wrap, load_err, alarm;

    logic [4:0] hour24;
    logic [5:0] minute24, second24;
    logic       sec_tick24, day_wrap24, load_err24, alarm24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    watch_hms #(.TICK_DIV(TICK_DIV), .HOURS(HOURS)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
        .hour(hour), .minute(minute), .second(second),
        .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_arm(alarm_arm), .alarm_clr(alarm_clr), .alarm(alarm)
    );

    watch_hms #(.TICK_DIV(TICK_DIV), .HOURS(24)) u_dut24 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
        .hour(hour24), .minute(minute24), .second(second24),
        .sec_tick(sec_tick24), .day_wrap(day_wrap24), .load_err(load_err24),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_arm(alarm_arm), .alarm_clr(alarm_clr), .alarm(alarm24)
    );

`ifdef ALARM_EN
    localparam logic ALARM_ON = 1'b1;
`else
    localparam logic ALARM_ON = 1'b0;
`endif

    // Reference model: time kept as seconds since midnight, prescaler as a plain count.
    int   m_t, m_pre;
    logic m_tick, m_wrap, m_err, m_alarm;

    task automatic model_reset();
        m_t = 0; m_pre = 0;
        m_tick = 0; m_wrap = 0; m_err = 0; m_alarm = 0;
    endtask

    task automatic model_step();
        bit legal, tk;
        if (rst) begin
            model_reset();
            return;
        end
        legal  = load && (int'(load_hour) < HOURS) && (load_minute < 60) && (load_second < 60);
        tk     = en && (m_pre == TICK_DIV - 1);
        m_err  = load && !legal;
        m_tick = 0;
        m_wrap = 0;
        if (legal) begin
            m_t   = int'(load_hour) * 3600 + int'(load_minute) * 60 + int'(load_second);
            m_pre = 0;
        end else begin
            if (en) m_pre = (m_pre + 1) % TICK_DIV;
            if (tk) begin
                m_t    = (m_t + 1) % (HOURS * 3600);
                m_tick = 1;
                m_wrap = (m_t == 0);
`ifdef ALARM_EN
                if (alarm_arm && m_t == int'(alarm_hour) * 3600 + int'(alarm_minute) * 60)
                    m_alarm = 1;
`endif
            end
        end
        if (alarm_clr || !alarm_arm) m_alarm = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hour"},     32'(hour),     32'(m_t / 3600));
        chk({tag, ".minute"},   32'(minute),   32'((m_t / 60) % 60));
        chk({tag, ".second"},   32'(second),   32'(m_t % 60));
        chk({tag, ".sec_tick"}, 32'(sec_tick), 32'(m_tick));
        chk({tag, ".day_wrap"}, 32'(day_wrap), 32'(m_wrap));
        chk({tag, ".load_err"}, 32'(load_err), 32'(m_err));
        chk({tag, ".alarm"},    32'(alarm),    32'(m_alarm));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".hour"},     32'(hour),     0);
        chk({tag, ".minute"},   32'(minute),   0);
        chk({tag, ".second"},   32'(second),   0);
        chk({tag, ".sec_tick"}, 32'(sec_tick), 0);
        chk({tag, ".day_wrap"}, 32'(day_wrap), 0);
        chk({tag, ".load_err"}, 32'(load_err), 0);
        chk({tag, ".alarm"},    32'(alarm),    0);
        chk({tag, ".hour24"},   32'(hour24),   0);
    endtask

    task automatic set_load(input logic ld, input int h, input int m, input int s);
        load        = ld;
        load_hour   = 5'(h);
        load_minute = 6'(m);
        load_second = 6'(s);
    endtask

    typedef struct {
        logic       ld;
        logic [4:0] lh;
        logic [5:0] lm, ls;
        logic       e;
        logic [4:0] h;
        logic [5:0] m, s;
        logic       tk, wr, er;
    } vec_t;

    function automatic vec_t mk(input logic ld, input int lh, input int lm, input int ls,
                                input logic e, input int h, input int m, input int s,
                                input logic tk, input logic wr, input logic er);
        vec_t v;
        v.ld = ld; v.lh = 5'(lh); v.lm = 6'(lm); v.ls = 6'(ls); v.e = e;
        v.h = 5'(h); v.m = 6'(m); v.s = 6'(s); v.tk = tk; v.wr = wr; v.er = er;
        return v;
    endfunction

    vec_t vecs[29];

    initial begin
        // Each row is one clock edge: inputs applied, outputs expected after the edge.
        vecs[0]  = mk(1, 11, 59, 58, 0, 11, 59, 58, 0, 0, 0);
        vecs[1]  = mk(0,  0,  0,  0, 1, 11, 59, 58, 0, 0, 0);
        vecs[2]  = mk(0,  0,  0,  0, 1, 11, 59, 58, 0, 0, 0);
        vecs[3]  = mk(0,  0,  0,  0, 1, 11, 59, 58, 0, 0, 0);
        vecs[4]  = mk(0,  0,  0,  0, 1, 11, 59, 59, 1, 0, 0);
        vecs[5]  = mk(0,  0,  0,  0, 1, 11, 59, 59, 0, 0, 0);
        vecs[6]  = mk(0,  0,  0,  0, 1, 11, 59, 59, 0, 0, 0);
        vecs[7]  = mk(0,  0,  0,  0, 1, 11, 59, 59, 0, 0, 0);
        vecs[8]  = mk(0,  0,  0,  0, 1,  0,  0,  0, 1, 1, 0);
        vecs[9]  = mk(0,  0,  0,  0, 1,  0,  0,  0, 0, 0, 0);
        vecs[10] = mk(1, 12,  0,  0, 1,  0,  0,  0, 0, 0, 1);
        vecs[11] = mk(1,  0, 60,  0, 1,  0,  0,  0, 0, 0, 1);
        vecs[12] = mk(1,  5,  0, 60, 1,  0,  0,  1, 1, 0, 1);
        vecs[13] = mk(0,  0,  0,  0, 1,  0,  0,  1, 0, 0, 0);
        vecs[14] = mk(0,  0,  0,  0, 1,  0,  0,  1, 0, 0, 0);
        vecs[15] = mk(0,  0,  0,  0, 1,  0,  0,  1, 0, 0, 0);
        vecs[16] = mk(1,  3,  7, 45, 1,  3,  7, 45, 0, 0, 0);
        vecs[17] = mk(0,  0,  0,  0, 1,  3,  7, 45, 0, 0, 0);
        vecs[18] = mk(0,  0,  0,  0, 1,  3,  7, 45, 0, 0, 0);
        vecs[19] = mk(0,  0,  0,  0, 1,  3,  7, 45, 0, 0, 0);
        vecs[20] = mk(0,  0,  0,  0, 1,  3,  7, 46, 1, 0, 0);
        vecs[21] = mk(0,  0,  0,  0, 0,  3,  7, 46, 0, 0, 0);
        vecs[22] = mk(0,  0,  0,  0, 1,  3,  7, 46, 0, 0, 0);
        vecs[23] = mk(0,  0,  0,  0, 0,  3,  7, 46, 0, 0, 0);
        vecs[24] = mk(0,  0,  0,  0, 0,  3,  7, 46, 0, 0, 0);
        vecs[25] = mk(0,  0,  0,  0, 1,  3,  7, 46, 0, 0, 0);
        vecs[26] = mk(0,  0,  0,  0, 1,  3,  7, 46, 0, 0, 0);
        vecs[27] = mk(0,  0,  0,  0, 0,  3,  7, 46, 0, 0, 0);
        vecs[28] = mk(0,  0,  0,  0, 1,  3,  7, 47, 1, 0, 0);

        model_reset();

        // Reset held for three edges, then counting from zero.
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_model("count");
            chk("count.sec_tick_exact", 32'(sec_tick), 32'(i == 4 || i == 8));
            chk("count.second_exact",   32'(second),   32'(i / 4));
        end

        // Vector table.
        for (int i = 0; i < 29; i++) begin
            set_load(vecs[i].ld, int'(vecs[i].lh), int'(vecs[i].lm), int'(vecs[i].ls));
            en = vecs[i].e;
            step();
            chk($sformatf("vec%0d.hour", i),     32'(hour),     32'(vecs[i].h));
            chk($sformatf("vec%0d.minute", i),   32'(minute),   32'(vecs[i].m));
            chk($sformatf("vec%0d.second", i),   32'(second),   32'(vecs[i].s));
            chk($sformatf("vec%0d.sec_tick", i), 32'(sec_tick), 32'(vecs[i].tk));
            chk($sformatf("vec%0d.day_wrap", i), 32'(day_wrap), 32'(vecs[i].wr));
            chk($sformatf("vec%0d.load_err", i), 32'(load_err), 32'(vecs[i].er));
        end
        set_load(0, 0, 0, 0);

        // HOURS=24 wrap from 23:59:59; the HOURS=12 instance rejects the same load.
        en = 1'b0;
        set_load(1, 23, 59, 59);
        step();
        check_model("h24load");
        chk("h24load.hour", 32'(hour24), 23);
        set_load(0, 0, 0, 0);
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_model("h24run");
            chk("h24.hour",     32'(hour24),     (i == 4) ? 0 : 23);
            chk("h24.second",   32'(second24),   (i == 4) ? 0 : 59);
            chk("h24.day_wrap", 32'(day_wrap24), 32'(i == 4));
        end

        // Alarm at 7:30, armed then disarmed.
        alarm_hour   = 5'd7;
        alarm_minute = 6'd30;
        alarm_arm    = 1'b1;
        set_load(1, 7, 29, 59);
        step();
        set_load(0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check_model("alarm_arm");
            chk("alarm.set", 32'(alarm), 32'(i >= 4 && ALARM_ON));
        end
        alarm_clr = 1'b1;
        step();
        check_model("alarm_clr");
        chk("alarm.clr", 32'(alarm), 0);
        alarm_clr = 1'b0;
        alarm_arm = 1'b0;
        set_load(1, 7, 29, 59);
        step();
        set_load(0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_model("alarm_disarmed");
        end

        // Asynchronous reset between edges.
        set_load(1, 5, 12, 33);
        step();
        set_load(0, 0, 0, 0);
        check_model("pre_async");
        @(posedge clk);
        model_step();
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_model("post_async");
        end
        chk("post_async.second", 32'(second), 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 19) == 0);
            load_hour = 5'($urandom_range(0, 13));
            load_minute = ($urandom_range(0, 1) == 0) ? 6'd59 : 6'($urandom_range(0, 61));
            load_second = 6'($urandom_range(50, 61));
            alarm_arm   = ($urandom_range(0, 9) != 0);
            alarm_clr   = ($urandom_range(0, 29) == 0);
            alarm_hour  = 5'($urandom_range(0, 3));
            alarm_minute = 6'd0;
            step();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
